// File: rtl/geo_pkg.sv
// geo_pkg: shared pixel record, writer FSM states and coordinate width for the geometry unit.
package geo_pkg;
  localparam int GEO_COORD_W = 12;
  typedef struct packed {
    logic signed [GEO_COORD_W-1:0] x, y;
    logic [7:0] c;
  } geo_pixel_t;
  typedef enum logic [1:0] {PW_IDLE, PW_CALC, PW_REQ} geo_pw_state_t;
endpackage

// File: rtl/geo_pixel_fifo.sv
// geo_pixel_fifo: synchronous FIFO of geo_pixel_t with push, pop, full, empty and count.
module geo_pixel_fifo
  import geo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  geo_pixel_t               din,
  output geo_pixel_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  geo_pixel_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/geo_pixel_writer.sv
// geo_pixel_writer: buffers generator pixels and issues byte-enabled 16-bit display writes.
// Optional input clipping and clip_cnt port are enabled by defining GEO_PIXEL_CLIP_EN.
module geo_pixel_writer
  import geo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 20
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pix_rdy,
  input  logic signed [GEO_COORD_W-1:0] pix_x,
  input  logic signed [GEO_COORD_W-1:0] pix_y,
  input  logic [7:0]                    color,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [11:0]                   width,
  input  logic [11:0]                   height,
  output logic                          pause,
  output logic                          wr_req,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [1:0]                    wr_be,
  output logic [15:0]                   wr_data,
  input  logic                          wr_ack,
  output logic                          busy
`ifdef GEO_PIXEL_CLIP_EN
  ,
  output logic [15:0]                   clip_cnt
`endif
);
  geo_pw_state_t state, nxt;
  geo_pixel_t head, cur;
  logic push, pop, take, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [23:0] prod;
  logic [ADDR_W-1:0] byte_addr;
`ifdef GEO_PIXEL_CLIP_EN
  logic clip;
  assign clip = pix_x[GEO_COORD_W-1] | pix_y[GEO_COORD_W-1] |
                ($unsigned(pix_x) >= width) | ($unsigned(pix_y) >= height);
  assign push = pix_rdy & ~clip;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clip_cnt <= '0;
    else if (pix_rdy && clip && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 1'b1;
  end
`else
  logic unused_height;
  assign unused_height = ^height;
  assign push = pix_rdy;
`endif
  geo_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ('{x: pix_x, y: pix_y, c: color}),
    .dout    (head),
    .full    (pause),
    .empty   (empty),
    .count   (count)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PW_IDLE;
    else state <= nxt;
  end
  always_comb begin
    take = state == PW_IDLE || (state == PW_REQ && wr_ack);
    pop  = take && !empty;
    nxt  = state == PW_CALC ? PW_REQ : take ? (empty ? PW_IDLE : PW_CALC) : state;
  end
  // Coordinates are treated as unsigned here; clipping, when enabled, already removed negatives.
  assign prod      = 24'($unsigned(cur.y)) * 24'(width);
  assign byte_addr = base_addr + ADDR_W'(prod) + ADDR_W'($unsigned(cur.x));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= '0;
      wr_addr <= '0;
      wr_be   <= '0;
      wr_data <= '0;
    end else begin
      if (pop) cur <= head;
      if (state == PW_CALC) begin
        wr_addr <= byte_addr >> 1;
        wr_be   <= cur.x[0] ? 2'b10 : 2'b01;
        wr_data <= {cur.c, cur.c};
      end
    end
  end
  assign wr_req = state == PW_REQ;
  assign busy   = count != '0 || state != PW_IDLE;
endmodule

// File: tb/tb_geo_pixel_writer.sv
// tb_geo_pixel_writer: directed self-checking bench for geo_pixel_writer.
module tb_geo_pixel_writer;
  logic clk = 1'b0, reset_n = 1'b0, pix_rdy = 1'b0, wr_ack = 1'b0;
  logic signed [11:0] pix_x = '0, pix_y = '0;
  logic [7:0] color = '0;
  logic [19:0] base_addr = 20'h100;
  logic [11:0] width = 12'd640, height = 12'd480;
  logic pause, wr_req, busy;
  logic [19:0] wr_addr;
  logic [1:0] wr_be;
  logic [15:0] wr_data;
`ifdef GEO_PIXEL_CLIP_EN
  logic [15:0] clip_cnt;
`endif
  int checks = 0, failures = 0;
  logic [37:0] log_q[$];
  logic [37:0] snap;

  geo_pixel_writer #(.FIFO_DEPTH(4), .ADDR_W(20)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_rdy   (pix_rdy),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .color     (color),
    .base_addr (base_addr),
    .width     (width),
    .height    (height),
    .pause     (pause),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy)
`ifdef GEO_PIXEL_CLIP_EN
    ,
    .clip_cnt  (clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n && wr_req && wr_ack) log_q.push_back({wr_addr, wr_be, wr_data});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [7:0] c);
    pix_rdy = 1'b1;
    pix_x = 12'(x);
    pix_y = 12'(y);
    color = c;
    tick();
    pix_rdy = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 100 && log_q.size() < n; k++) tick();
  endtask

  function automatic logic [37:0] exp_wr(input int x, input int y, input logic [7:0] c);
    logic [19:0] a;
    a = 20'(32'h100 + y * 640 + x);
    return {a >> 1, x[0] ? 2'b10 : 2'b01, c, c};
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_pause", pause, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_be", wr_be, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    wr_ack = 1'b1;
    send(3, 2, 8'h5A);
    chk("lat_n0_req", wr_req, 0);
    chk("lat_n0_busy", busy, 1);
    tick();
    chk("lat_n1_req", wr_req, 0);
    tick();
    chk("lat_n2_req", wr_req, 1);
    chk("single_addr", wr_addr, 20'h00301);
    chk("single_be", wr_be, 2'b10);
    chk("single_data", wr_data, 16'h5A5A);
    tick();
    chk("single_done_req", wr_req, 0);
    chk("single_done_busy", busy, 0);
    chk("single_count", log_q.size(), 1);

    log_q.delete();
    wr_ack = 1'b0;
    begin
      int i, cyc;
      logic sent;
      i = 0;
      cyc = 0;
      while (i < 16 && cyc < 300) begin
        wr_ack = cyc >= 20;
        pix_rdy = !pause;
        pix_x = 12'(i);
        pix_y = 12'sd1;
        color = 8'(i + 16);
        sent = pix_rdy;
        tick();
        cyc++;
        if (sent) begin
          i++;
          if (i == 5) chk("bp_pause_full", pause, 1);
        end
      end
      pix_rdy = 1'b0;
      chk("bp_all_sent", i, 16);
    end
    wr_ack = 1'b1;
    wait_writes(16);
    repeat (5) tick();
    chk("bp_count", log_q.size(), 16);
    for (int j = 0; j < 16 && j < log_q.size(); j++)
      chk($sformatf("bp_wr%0d", j), log_q[j], exp_wr(j, 1, 8'(j + 16)));
    chk("bp_idle_busy", busy, 0);

    log_q.delete();
    wr_ack = 1'b0;
    send(5, 7, 8'hC3);
    for (int k = 0; k < 10 && !wr_req; k++) tick();
    chk("hold_req", wr_req, 1);
    snap = {wr_addr, wr_be, wr_data};
    chk("hold_value", snap, {20'h00942, 2'b10, 16'hC3C3});
    repeat (5) begin
      tick();
      chk("hold_stable", {wr_req, wr_addr, wr_be, wr_data}, {1'b1, snap});
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    tick();
    tick();
    chk("hold_count", log_q.size(), 1);
    chk("hold_done_req", wr_req, 0);

    log_q.delete();
    wr_ack = 1'b1;
`ifdef GEO_PIXEL_CLIP_EN
    send(-1, 0, 8'h21);
    chk("clip_pause0", pause, 0);
    send(640, 5, 8'h22);
    chk("clip_pause1", pause, 0);
    send(10, 480, 8'h23);
    chk("clip_pause2", pause, 0);
    send(639, 479, 8'h24);
    chk("clip_pause3", pause, 0);
    wait_writes(1);
    repeat (5) tick();
    chk("clip_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("clip_wr", log_q[0], {20'h2587F, 2'b10, 16'h2424});
    chk("clip_cnt", clip_cnt, 3);
`else
    send(-1, 0, 8'h11);
    wait_writes(1);
    repeat (5) tick();
    chk("noclip_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("noclip_wr", log_q[0], {20'h0087F, 2'b10, 16'h1111});
`endif

    log_q.delete();
    wr_ack = 1'b0;
    for (int k = 0; k < 4; k++) send(20 + k, 3, 8'(k + 1));
    for (int k = 0; k < 10 && !wr_req; k++) tick();
    chk("mid_req", wr_req, 1);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", wr_req, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_be", wr_be, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pause", pause, 0);
    tick();
    reset_n = 1'b1;
    wr_ack = 1'b1;
    repeat (10) tick();
    chk("post_rst_writes", log_q.size(), 0);
    chk("post_rst_req", wr_req, 0);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
